debounce_ctrl: RTL
==================

// Module: debounce_ctrl
// PURPOSE
//  Conditions N raw push-button/switch inputs into clean, glitch-free control signals for the lab datapath.
//  Each input passes through a 2-flop sync chain, then a per-channel debounce state machine.
//  All channels share one time-base prescaler.
//  Outputs a debounced level plus one-cycle press/release pulses (e.g. Run, ClearA_LoadB) to the control FSM.
// PARAMETERS
//  N_CH          4      number of independent input channels
//  TICK_DIV      50000  Clk cycles per debounce tick (1 ms at 50 MHz); must be >= 2
//  STABLE_TICKS  10     consecutive stable ticks required to accept a new level; must be >= 2
//  ACTIVE_LOW_IN 1      1: raw_in low means pressed (board KEYs); 0: high means pressed
// PORTS
//  Clk            in   1     system clock
//  Reset          in   1     asynchronous, active-low reset
//  raw_in         in   N_CH  asynchronous raw button/switch inputs
//  level_out      out  N_CH  debounced level, 1 = pressed
//  press_pulse    out  N_CH  one-Clk pulse when the channel's debounced level goes 0->1
//  release_pulse  out  N_CH  one-Clk pulse when the channel's debounced level goes 1->0
//  busy           out  1     1 while any channel is in a CHK state
// BEHAVIOUR
//  Reset (Reset=0, async):
//   - all outputs 0; every channel in RELEASED; prescaler and stable counters 0.
//   - Sync flops carry no reset; their contents are don't-care until 2 Clk after Reset deasserts.
//  Sync: s[i] = 2-flop-delayed raw_in[i], XOR-normalised by ACTIVE_LOW_IN so that 1 = pressed.
//  Prescaler:
//   - counts 0..TICK_DIV-1 and wraps.
//   - tick=1 for the single cycle in which the count equals TICK_DIV-1.
//   - free-running; never restarted by channel activity.
//  Channel FSM (states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK):
//   - RELEASED: s=1 -> PRESS_CHK, cnt<=0. A tick in the entry cycle is not counted.
//   - PRESS_CHK: s=0 on any cycle -> RELEASED, cnt<=0 (bounce rejected, no pulse).
//     Otherwise, on a tick: cnt<=cnt+1.
//     On the tick where cnt==STABLE_TICKS-1 -> PRESSED, level_out<=1, press_pulse<=1.
//   - PRESSED: s=0 -> RELEASE_CHK, cnt<=0.
//   - RELEASE_CHK: mirror of PRESS_CHK with s=1 as the abort condition.
//     Acceptance -> RELEASED, level_out<=0, release_pulse<=1.
//   - If s aborts on the same cycle as the confirming tick, the abort wins.
//  Outputs are registered.
//   - A pulse is visible the cycle after the confirming tick edge and lasts exactly one cycle.
//   - press_pulse and release_pulse are never both 1 for the same channel.
//  Latency from the raw edge to level_out change:
//   - 2 sync cycles + 1 entry cycle + the time to the STABLE_TICKS-th subsequent tick + 1 output cycle.
//   - Range: (STABLE_TICKS-1)*TICK_DIV+4 .. STABLE_TICKS*TICK_DIV+3 cycles.
//  Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
//  busy = OR over channels of (state==PRESS_CHK || state==RELEASE_CHK).
//  Widths:
//   - prescaler: $clog2(TICK_DIV) bits.
//   - cnt: $clog2(STABLE_TICKS) bits.
//   - Neither counter ever exceeds its terminal value; no other wrap-around exists.
//  Reset asserted mid-check: channel returns to RELEASED at once; no pulse is emitted.
// STRUCTURE
//  debounce_pkg:
//   - db_state_t enum {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK}
//   - localparam helpers TICK_W, CNT_W
//  Sub-module debounce_ch: one channel's FSM, stable counter and output registers.
//   - inputs: Clk, Reset, s, tick
//   - outputs: level, press, release, chk
//  Top debounce_ctrl contains:
//   - prescaler
//   - per-channel generate loop: two sync instances per channel, one debounce_ch per channel
//   - busy OR-reduce
// TESTING (TICK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW_IN=1, N_CH=4)
//  1. Reset: hold Reset=0 with raw_in=4'hF, release Reset, run 50 cycles.
//     -> level_out=0, no pulses, busy=0 throughout.
//  2. Clean press: drive raw_in[0] 1->0 and hold.
//     -> press_pulse[0] high for exactly 1 cycle, 12..15 cycles after the edge; level_out[0]=1 after; busy high during the check.
//  3. Bounce: toggle raw_in[1] low/high every 5 cycles for 40 cycles, then hold high.
//     -> no pulses; level_out[1] stays 0; busy returns to 0.
//  4. Release: after test 2, drive raw_in[0] high.
//     -> release_pulse[0] for 1 cycle within 12..15 cycles; level_out[0]=0.
//  5. Simultaneous: press channels 2 and 3 on the same cycle.
//     -> press_pulse[2] and press_pulse[3] asserted in the same cycle.
//  6. Reset mid-check: assert Reset 6 cycles into a press check on channel 0.
//     -> outputs 0 immediately; no pulse after release; a new press is then accepted normally.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the button/switch debounce block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   db_state_t   per-channel debounce state
//   clog2_min1   counter width helper, never returns 0
//   TICK_W       prescaler width for the default tick divider
//   CNT_W        stable-counter width for the default stable tick count
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_t;

  localparam int unsigned DEF_TICK_DIV     = 50000;
  localparam int unsigned DEF_STABLE_TICKS = 10;

  // A counter over 0..n-1 needs $clog2(n) bits; keep at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned TICK_W = clog2_min1(DEF_TICK_DIV);
  localparam int unsigned CNT_W  = clog2_min1(DEF_STABLE_TICKS);

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: state machine, stable-tick counter, registered outputs.
// Latency: output changes one Clk after the confirming tick edge.
// Backpressure: none; consumes s_i/tick_i every cycle.
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous active-low reset
//   s_i        synchronised input, 1 = pressed
//   tick_i     shared time-base tick (one cycle wide)
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse on accepted 0->1
//   release_o  one-cycle pulse on accepted 1->0
//   chk_o      channel is currently verifying a candidate level
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic s_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic chk_o
);

  localparam int unsigned     CW       = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Entry into a CHK state ignores any tick in that same cycle; the counter
  // only starts counting on ticks that arrive while already checking.
  // An abort (s back to the old level) takes priority over a confirming tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s_i) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s_i) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PRESSED: begin
        if (!s_i) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (s_i) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign chk_o     = (state_q == PRESS_CHK) || (state_q == RELEASE_CHK);

endmodule

// File: rtl/debounce_ctrl.sv
// Debounces N_CH raw buttons/switches into clean levels and press/release pulses.
// Latency: (STABLE_TICKS-1)*TICK_DIV+4 .. STABLE_TICKS*TICK_DIV+3 Clk from raw edge.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
//
// Ports:
//   Clk            system clock
//   Reset          asynchronous active-low reset
//   raw_in         asynchronous raw inputs (polarity set by ACTIVE_LOW_IN)
//   level_out      debounced level per channel, 1 = pressed
//   press_pulse    one-cycle pulse per channel on accepted press
//   release_pulse  one-cycle pulse per channel on accepted release
//   busy           any channel currently checking a candidate level
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
  parameter bit          ACTIVE_LOW_IN = 1'b1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            busy
);

  localparam int unsigned   TW         = clog2_min1(TICK_DIV);
  localparam logic [TW-1:0] PRESC_LAST = TW'(TICK_DIV - 1);

  // Free-running time base shared by all channels; channel activity never
  // restarts it, so tick phase relative to an input edge is arbitrary.
  logic [TW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + TW'(1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  logic [N_CH-1:0] chk;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Synchroniser flops deliberately carry no reset; their content is
    // flushed within two clocks of the raw input settling.
    logic meta_q;
    logic sync_q;
    logic s;

    always_ff @(posedge Clk) begin
      meta_q <= raw_in[i];
      sync_q <= meta_q;
    end

    assign s = sync_q ^ ACTIVE_LOW_IN;

    debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .Clk       (Clk),
      .Reset     (Reset),
      .s_i       (s),
      .tick_i    (tick),
      .level_o   (level_out[i]),
      .press_o   (press_pulse[i]),
      .release_o (release_pulse[i]),
      .chk_o     (chk[i])
    );
  end

  assign busy = |chk;

endmodule
